// File: rtl/sound_pkg.sv
// Shared types and melody tables for the sound sequencer.
// Melodies are packed 4-bit note indices, first note in the low nibble.
package sound_pkg;

  typedef enum logic [1:0] {
    SND_NONE      = 2'd0,
    SND_COLLISION = 2'd1,
    SND_LOSE      = 2'd2,
    SND_WIN       = 2'd3
  } sound_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int MAX_NOTES = 4;

  localparam logic [15:0] WIN_MELODY       = {4'd12, 4'd9, 4'd7, 4'd5};
  localparam logic [15:0] LOSE_MELODY      = {4'd1, 4'd3, 4'd5, 4'd7};
  localparam logic [15:0] COLLISION_MELODY = {4'd0, 4'd0, 4'd0, 4'd5};

  localparam logic [1:0] WIN_LAST_IDX       = 2'd3;
  localparam logic [1:0] LOSE_LAST_IDX      = 2'd3;
  localparam logic [1:0] COLLISION_LAST_IDX = 2'd0;

endpackage

// File: rtl/sound_melody_rom.sv
// Combinational melody lookup: note index for (sound, position) and whether
// that position is the final note of the melody.
module sound_melody_rom
  import sound_pkg::*;
(
  input  sound_id_t  id,
  input  logic [1:0] idx,
  output logic [3:0] freq,
  output logic       last
);

  always_comb begin
    freq = 4'd0;
    last = 1'b1;
    unique case (id)
      SND_WIN: begin
        freq = WIN_MELODY[{idx, 2'b00} +: 4];
        last = (idx == WIN_LAST_IDX);
      end
      SND_LOSE: begin
        freq = LOSE_MELODY[{idx, 2'b00} +: 4];
        last = (idx == LOSE_LAST_IDX);
      end
      SND_COLLISION: begin
        freq = COLLISION_MELODY[{idx, 2'b00} +: 4];
        last = (idx == COLLISION_LAST_IDX);
      end
      default: begin
        freq = 4'd0;
        last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sound_sequencer.sv
// Event-driven melody sequencer for the tone generator: captures game event
// pulses, arbitrates by sound id and steps notes on video-frame ticks.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int NOTE_FRAMES = 6,
  parameter int GAP_FRAMES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       winPulse,
  input  logic       losePulse,
  input  logic       collisionPulse,
  input  logic       mute,
  output logic       enable_sound,
  output logic [3:0] freq,
  output logic       busy,
  output logic [1:0] active_sound
);

  localparam int MAX_FRAMES = (NOTE_FRAMES > GAP_FRAMES) ? NOTE_FRAMES : GAP_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FRAMES - 1);

  state_t           state, state_next;
  sound_id_t        active, active_next, hp, rom_id;
  logic [3:1]       pending, pending_next, pending_clr;
  logic [CNT_W-1:0] frame_cnt, cnt_next;
  logic [1:0]       note_idx, idx_next, rom_idx;
  logic [3:0]       freq_q, freq_next, rom_freq;
  logic             note_last, last_next, rom_last;
  logic             enable_q, enable_next;
  logic             start;

  // Bit 3 = win, 2 = lose, 1 = collision, so the highest set bit is the id.
  always_comb begin
    if (pending[3])      hp = SND_WIN;
    else if (pending[2]) hp = SND_LOSE;
    else if (pending[1]) hp = SND_COLLISION;
    else                 hp = SND_NONE;
  end

  assign start = (hp != SND_NONE) && ((state == IDLE) || (hp >= active));

  // One lookup serves both a fresh start and the advance to the next note.
  assign rom_id  = start ? hp : active;
  assign rom_idx = start ? 2'd0 : note_idx + 2'd1;

  sound_melody_rom u_rom (
    .id   (rom_id),
    .idx  (rom_idx),
    .freq (rom_freq),
    .last (rom_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      frame_cnt <= '0;
      note_idx  <= 2'd0;
      active    <= SND_NONE;
      freq_q    <= 4'd0;
      note_last <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      frame_cnt <= cnt_next;
      note_idx  <= idx_next;
      active    <= active_next;
      freq_q    <= freq_next;
      note_last <= last_next;
      enable_q  <= enable_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = IDLE;
      PLAY: if (startOfFrame && frame_cnt == NOTE_LAST) state_next = GAP;
      GAP:  if (startOfFrame && frame_cnt == GAP_LAST)  state_next = note_last ? IDLE : PLAY;
      default: state_next = IDLE;
    endcase
    if (start) state_next = PLAY;
  end

  always_comb begin
    cnt_next    = frame_cnt;
    idx_next    = note_idx;
    active_next = active;
    freq_next   = freq_q;
    last_next   = note_last;
    pending_clr = 3'b000;
    if (start) begin
      cnt_next    = '0;
      idx_next    = 2'd0;
      active_next = hp;
      freq_next   = rom_freq;
      last_next   = rom_last;
      // Win and lose also discard any queued collision click.
      unique case (hp)
        SND_WIN:       pending_clr = 3'b101;
        SND_LOSE:      pending_clr = 3'b011;
        SND_COLLISION: pending_clr = 3'b001;
        default:       pending_clr = 3'b000;
      endcase
    end else if (startOfFrame) begin
      unique case (state)
        PLAY: cnt_next = (frame_cnt == NOTE_LAST) ? '0 : frame_cnt + CNT_W'(1);
        GAP: begin
          if (frame_cnt == GAP_LAST) begin
            cnt_next = '0;
            if (note_last) begin
              active_next = SND_NONE;
            end else begin
              idx_next  = note_idx + 2'd1;
              freq_next = rom_freq;
              last_next = rom_last;
            end
          end else begin
            cnt_next = frame_cnt + CNT_W'(1);
          end
        end
        default: cnt_next = frame_cnt;
      endcase
    end
    pending_next = (pending & ~pending_clr) | {winPulse, losePulse, collisionPulse};
    enable_next  = (state_next == PLAY) && !mute;
  end

  assign enable_sound = enable_q;
  assign freq         = freq_q;
  assign busy         = (state != IDLE);
  assign active_sound = active;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with NOTE_FRAMES=6, GAP_FRAMES=1.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       winPulse = 1'b0;
  logic       losePulse = 1'b0;
  logic       collisionPulse = 1'b0;
  logic       mute = 1'b0;
  logic       enable_sound;
  logic [3:0] freq;
  logic       busy;
  logic [1:0] active_sound;

  int checks = 0;
  int failures = 0;
  int win_notes [4] = '{5, 7, 9, 12};

  sound_sequencer #(.NOTE_FRAMES(6), .GAP_FRAMES(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .winPulse       (winPulse),
    .losePulse      (losePulse),
    .collisionPulse (collisionPulse),
    .mute           (mute),
    .enable_sound   (enable_sound),
    .freq           (freq),
    .busy           (busy),
    .active_sound   (active_sound)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One video frame: a tick pulse followed by one quiet cycle.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic start_win();
    winPulse = 1'b1;
    tick();
    winPulse = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_en", enable_sound, 0);
    chk("rst_freq", freq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_sound, 0);
    reset = 1'b0;
    tick();

    // Collision click from idle
    collisionPulse = 1'b1;
    tick();
    collisionPulse = 1'b0;
    chk("coll_pre_en", enable_sound, 0);
    tick();
    chk("coll_en", enable_sound, 1);
    chk("coll_freq", freq, 5);
    chk("coll_active", active_sound, 1);
    chk("coll_busy", busy, 1);
    frames(5);
    chk("coll_en_f5", enable_sound, 1);
    frame();
    chk("coll_en_f6", enable_sound, 0);
    chk("coll_busy_gap", busy, 1);
    frame();
    chk("coll_busy_end", busy, 0);
    chk("coll_active_end", active_sound, 0);
    chk("coll_freq_hold", freq, 5);

    // Full win melody
    start_win();
    for (int n = 0; n < 4; n++) begin
      chk("win_freq", freq, win_notes[n]);
      chk("win_en", enable_sound, 1);
      chk("win_active", active_sound, 3);
      frames(5);
      chk("win_en_f5", enable_sound, 1);
      frame();
      chk("win_gap_en", enable_sound, 0);
      chk("win_gap_freq", freq, win_notes[n]);
      chk("win_gap_active", active_sound, 3);
      frame();
    end
    chk("win_busy_end", busy, 0);
    chk("win_active_end", active_sound, 0);

    // Lose requested during win note 2 waits for the win to finish
    start_win();
    frames(7);
    chk("wl_freq_n2", freq, 7);
    losePulse = 1'b1;
    tick();
    losePulse = 1'b0;
    chk("wl_active_win", active_sound, 3);
    frames(20);
    chk("wl_last_freq", freq, 12);
    chk("wl_still_win", active_sound, 3);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("wl_idle_busy", busy, 0);
    tick();
    chk("wl_lose_active", active_sound, 2);
    chk("wl_lose_freq", freq, 7);
    chk("wl_lose_en", enable_sound, 1);
    frames(28);
    chk("wl_lose_done", busy, 0);

    // Win preempts lose on note 1; lose is not requeued
    losePulse = 1'b1;
    tick();
    losePulse = 1'b0;
    tick();
    chk("pre_lose_active", active_sound, 2);
    chk("pre_lose_freq", freq, 7);
    frames(2);
    winPulse = 1'b1;
    tick();
    winPulse = 1'b0;
    chk("pre_still_lose", active_sound, 2);
    tick();
    chk("pre_win_active", active_sound, 3);
    chk("pre_win_freq", freq, 5);
    chk("pre_win_en", enable_sound, 1);
    frames(28);
    chk("pre_done", busy, 0);
    tick();
    tick();
    chk("pre_no_requeue", busy, 0);

    // Collision and win together: collision discarded
    collisionPulse = 1'b1;
    winPulse = 1'b1;
    tick();
    collisionPulse = 1'b0;
    winPulse = 1'b0;
    tick();
    chk("sim_active", active_sound, 3);
    chk("sim_freq", freq, 5);
    frames(28);
    chk("sim_done", busy, 0);
    tick();
    tick();
    tick();
    chk("sim_no_click", busy, 0);
    chk("sim_no_click_en", enable_sound, 0);

    // Mute during win note 1 keeps timing running
    start_win();
    frames(2);
    mute = 1'b1;
    tick();
    chk("mute_en", enable_sound, 0);
    chk("mute_freq", freq, 5);
    chk("mute_busy", busy, 1);
    frames(3);
    chk("mute_en_f3", enable_sound, 0);
    mute = 1'b0;
    tick();
    chk("unmute_en", enable_sound, 1);
    chk("unmute_freq", freq, 5);
    frame();
    chk("mute_timing_gap", enable_sound, 0);
    frame();
    chk("mute_timing_n2", freq, 7);
    chk("mute_timing_n2_en", enable_sound, 1);

    // Reset mid-win, with a pulse coincident with reset
    reset = 1'b1;
    winPulse = 1'b1;
    tick();
    reset = 1'b0;
    winPulse = 1'b0;
    chk("mrst_en", enable_sound, 0);
    chk("mrst_freq", freq, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_active", active_sound, 0);
    tick();
    tick();
    chk("mrst_pulse_dropped", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Sequences the tone generator's enable/freq inputs from game events.
- Arbitrates the win, lose and collision requests by fixed priority.
- Plays a short multi-note melody for each event, with note timing counted in video frames (startOfFrame).
- Sits between the game-logic event pulses and the audio tone generator, replacing a single-tone-per-event controller.

Parameters:
- NOTE_FRAMES, 6: frames each note sounds (>=1).
- GAP_FRAMES, 1: silent frames after each note (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame; the timing tick
- winPulse  in  1  one-cycle request, win melody
- losePulse  in  1  one-cycle request, lose melody
- collisionPulse  in  1  one-cycle request, collision click
- mute  in  1  level; silences output without affecting sequencing
- enable_sound  out  1  tone generator enable (registered)
- freq  out  4  tone generator note index (registered)
- busy  out  1  high whenever state != IDLE
- active_sound  out  2  sound_id_t of sound being played, SND_NONE when idle

Behaviour:
- Reset: one clock, synchronous and active-high. While reset is high:
  - state=IDLE, pending=0, frame_cnt=0, note_idx=0
  - enable_sound=0, freq=0, busy=0, active_sound=SND_NONE
  - Reset mid-melody aborts it silently at the next edge. Pulses coincident with reset are dropped.
- Priority: win(3) > lose(2) > collision(1), by numeric sound_id.
- Capture: each pulse sets its pending bit at the sampling edge. Simultaneous pulses set all bits. A pulse arriving while its bit is already set is merged.
- Start (any state, edge E): a start is taken when the highest pending id hp satisfies either:
  - state==IDLE, or
  - hp >= active_sound (preemption, or same-id retrigger).

  At edge E+1:
  - state=PLAY, active_sound=hp, note_idx=0, frame_cnt=0
  - freq=rom(hp,0), enable_sound=~mute
  - pending[hp] cleared
  - If hp is WIN or LOSE, pending[collision] is also cleared; stale clicks are discarded.

  Net latency: pulse sampled at edge N -> enable_sound high after edge N+1 (idle case).
- Lower-priority pending: stays pending during a higher-priority melody and starts from IDLE once that melody completes.
- PLAY:
  - On startOfFrame, frame_cnt increments.
  - When startOfFrame arrives with frame_cnt==NOTE_FRAMES-1: go to GAP, frame_cnt=0, enable_sound=0.
- GAP:
  - On startOfFrame with frame_cnt==GAP_FRAMES-1:
    - If the last note is done: go to IDLE, active_sound=NONE, freq unchanged.
    - Otherwise: note_idx+1, go to PLAY, freq=rom(id,idx+1), enable_sound=~mute.
- Simultaneous events: a start condition overrides any frame-timer transition in the same cycle.
- mute: enable_sound = (state==PLAY) & ~mute, updated on the next edge. Timers and state machine are unaffected.
- Counter width: $clog2(max(NOTE_FRAMES,GAP_FRAMES)). frame_cnt never exceeds its terminal value; no wrap.
- Melodies (freq index sequence, length):
  - WIN: 5,7,9,12 (4)
  - LOSE: 7,5,3,1 (4)
  - COLLISION: 5 (1)
- Melody duration: notes*(NOTE_FRAMES+GAP_FRAMES) frames. The first note's first frame may be partial, depending on start phase relative to startOfFrame.

Decomposition:
- sound_pkg:
  - enum logic[1:0] sound_id_t {SND_NONE=0, SND_COLLISION=1, SND_LOSE=2, SND_WIN=3}
  - enum state_t {IDLE, PLAY, GAP}
  - MAX_NOTES=4
  - melody note constants and lengths
- Sub-module sound_melody_rom: combinational.
  - Inputs: (sound_id_t id, [1:0] idx).
  - Outputs: (freq[3:0], last).
  - Returns freq=0, last=1 for SND_NONE.
- Top level holds the pending register, the priority select, the FSM and the frame counter.

Test Plan:
- Idle collisionPulse, NOTE_FRAMES=6, GAP_FRAMES=1:
  - enable_sound=1 and freq=5 one edge after pulse sampling.
  - enable_sound drops at the 6th subsequent startOfFrame.
  - busy falls one frame later.
- Idle winPulse: freq steps 5,7,9,12, each for 6 frames with 1 silent frame between; active_sound=3 throughout; IDLE after 28 frames.
- losePulse mid-win, note 2: win continues to completion, then lose starts next cycle from IDLE with freq=7.
- winPulse during lose note 1: next edge active_sound=3, freq=5, note_idx=0. Lose pending is not re-queued.
- collisionPulse and winPulse in the same cycle: win plays. Collision is discarded and never plays after win ends.
- Mid-win:
  - mute=1 for 3 frames: enable_sound=0 for those frames while freq and note timing continue unchanged.
  - reset=1 for 1 cycle: all outputs 0 and busy=0 at the next edge.
